// File: rtl/fifo_drv_pkg.sv
// Shared definitions for the FIFO write-side traffic generator: FSM state
// encoding and default sizing, also used by benches to decode the debug state.
package fifo_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } drv_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_COUNT_WIDTH  = 8;
  localparam int DEF_TIMEOUT_CLKS = 16;

  // Bits needed to count 0..clks-1 (clks is at least 2).
  function automatic int stall_cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/fifo_write_driver_stall_timer.sv
// Saturating stall counter; expired_o is high once TIMEOUT_CLKS-1 back-to-back
// stalled cycles have been counted since the last clear.
module stall_timer
  import fifo_drv_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = stall_cnt_width(TIMEOUT_CLKS);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/fifo_write_driver.sv
// Write-side traffic generator: pushes start_value, start_value+step, ... into a
// buffer write port under full back-pressure, aborting if full persists too long.
module fifo_write_driver
  import fifo_drv_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic signed [DATA_WIDTH-1:0]  start_value_i,
  input  logic signed [DATA_WIDTH-1:0]  step_i,
  input  logic        [COUNT_WIDTH-1:0] num_words_i,
  input  logic                          full_i,
  output logic                          wr_en_o,
  output logic signed [DATA_WIDTH-1:0]  wr_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic        [COUNT_WIDTH-1:0] words_sent_o,
  output drv_state_t                    state_o
);

  // Handshake: a word is transferred on every rising edge where wr_en_o is high;
  // wr_en_o is simply "in WRITE and not full", so full_i gates it in the same cycle.

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  drv_state_t                   state_q;
  logic signed [DATA_WIDTH-1:0] wr_data_q;
  logic signed [DATA_WIDTH-1:0] step_q;
  logic [COUNT_WIDTH-1:0]       num_q;
  logic [COUNT_WIDTH-1:0]       words_q;
  logic [COUNT_WIDTH-1:0]       words_inc;
  logic                         busy_q;
  logic                         done_q;
  logic                         timeout_q;

  logic accept;
  logic start_fire;
  logic stall_expired;

  assign accept     = (state_q == WRITE) && !full_i;
  assign start_fire = ((state_q == IDLE) || (state_q == ERROR)) && start_i;
  assign words_inc  = words_q + CNT_ONE;

  stall_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_stall_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_fire || accept),
    .enable_i ((state_q == WRITE) && full_i),
    .expired_o(stall_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_data_q <= '0;
      step_q    <= '0;
      num_q     <= '0;
      words_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (start_i) begin
            words_q <= '0;
            if (num_words_i != '0) begin
              step_q    <= step_i;
              num_q     <= num_words_i;
              wr_data_q <= start_value_i;
              timeout_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= WRITE;
            end else begin
              // Zero-length request completes immediately without writing.
              done_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            wr_data_q <= wr_data_q + step_q;
            words_q   <= words_inc;
            if (words_inc == num_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (stall_expired) begin
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ERROR;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_en_o      = accept;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign words_sent_o = words_q;
  assign state_o      = state_q;

endmodule

// File: doc/fifo_write_driver.md
# fifo_write_driver

Synthesizable write-side traffic generator for the FIFO/LIFO blocks: on a start command it pushes a programmable arithmetic sequence of signed words into a buffer's write port, honouring `full` back-pressure, and flags a timeout if the buffer stays full too long. It is the producer counterpart to the bench's value checkers, which wait for a signal to reach a goal within N clocks. It sits between a test controller (or on-chip BIST sequencer) and the DUT write interface.

## Interface
- `DATA_WIDTH`, 8, width of the signed data word.
- `COUNT_WIDTH`, 8, width of the word counter; max burst is 2^COUNT_WIDTH-1 words.
- `TIMEOUT_CLKS`, 16, consecutive cycles of `full` during a burst before abort; must be ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE or ERROR.
- `start_value`  in  DATA_WIDTH signed  first word written.
- `step`  in  DATA_WIDTH signed  increment added after each accepted word.
- `num_words`  in  COUNT_WIDTH  words in the burst.
- `full`  in  1  DUT full flag.
- `wr_en`  out  1  write strobe to DUT.
- `wr_data`  out  DATA_WIDTH signed  write data to DUT.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse on burst completion.
- `timeout`  out  1  sticky abort flag.
- `words_sent`  out  COUNT_WIDTH  words accepted in current/last burst.

## Operation
- States: IDLE, WRITE, DONE, ERROR.
- IDLE: `busy`=0. `start` && `num_words`≠0 → latch `step`/`num_words`, load `wr_data`←`start_value`, clear `words_sent` and `timeout`, go WRITE. `start` && `num_words`=0 → stay IDLE, pulse `done` next cycle, clear `words_sent`.
- WRITE: `busy`=1; `wr_en` = !`full` (combinational from `full`). A word is accepted on every edge where `wr_en`=1: `wr_data`←`wr_data`+`step` (two's-complement wrap, no saturation), `words_sent`+1, stall counter cleared. If that was word `num_words` → DONE.
- Stall: each WRITE cycle with `full`=1 increments stall counter; when counter reaches TIMEOUT_CLKS-1 with `full` still 1 → ERROR.
- DONE: `done`=1 for exactly one cycle, `busy`=0, → IDLE.
- ERROR: `timeout`=1, `busy`=0, `wr_en`=0; `words_sent` holds count reached. `start` restarts exactly as from IDLE.
- `start` while in WRITE or DONE is ignored; latched parameters are not changed mid-burst.
- `rst` (any state, including mid-burst): all state back to reset values next edge; no further writes.

## Timing
- Reset values: `wr_en`=0, `wr_data`=0, `busy`=0, `done`=0, `timeout`=0, `words_sent`=0, state IDLE, stall counter 0.
- Latency: `start` at edge N → `busy`=1 and first possible `wr_en` in cycle N+1.
- Unstalled burst of K words: `wr_en` high K consecutive cycles; `done` pulses in the cycle after the last write; `busy` low from that cycle.
- `full` rising mid-burst deasserts `wr_en` in the same cycle (no write lost or duplicated); `wr_data` holds while stalled.
- Timeout: `full` held from cycle M in WRITE → `timeout`=1 at cycle M+TIMEOUT_CLKS; `full` dropping in cycle M+TIMEOUT_CLKS-1 or earlier avoids it.
- `words_sent` wraps never: burst length bounded by COUNT_WIDTH.

## Structure
- Shared package `fifo_drv_pkg`: `drv_state_t` enum (IDLE, WRITE, DONE, ERROR) and default width/timeout constants, reused by benches for state decoding.
- One sub-module `stall_timer`: saturating counter with clear/enable, `expired` output at TIMEOUT_CLKS-1; top holds FSM and datapath.

## Test plan
- Reset then `start`, `start_value`=5, `step`=3, `num_words`=4, `full`=0 → `wr_data` 5,8,11,14 on 4 consecutive `wr_en` cycles; `done` pulse next; `words_sent`=4.
- `start_value`=120, `step`=10, `num_words`=3 → writes 120, -126, -116 (signed wrap).
- Burst of 6, `full`=1 for 3 cycles after 2nd word → exactly 6 writes, data contiguous, no duplicate, `done` 3 cycles later than unstalled case.
- `full` held 16 cycles after 1st word (TIMEOUT_CLKS=16) → `timeout`=1, `busy`=0, `words_sent`=1; new `start` clears `timeout` and bursts normally.
- `num_words`=0 → no `wr_en`, `done` pulse one cycle after `start`; `start` during active burst ignored.
- `rst` asserted after 2nd of 5 words → all outputs 0 next edge, no further `wr_en`.
